rr_select_arbiter: RTL and testbench
====================================

// Module: rr_select_arbiter
// PURPOSE
//  Round-robin arbiter sitting directly upstream of the 4:1 datapath mux.
//  Picks one of four requesting channels and drives the mux's 2-bit Control select.
//  Holds each grant for at most Max_Burst accepted beats, so no channel starves the mux output.
//  Gives downstream logic a one-hot Grant and a Grant_Valid qualifier.
// PARAMETERS
//  Max_Burst   4   max accepted beats per grant; legal range 1..255
//  Cnt_Width   8   beat counter width; must satisfy 2**Cnt_Width > Max_Burst
// PORTS
//  Clk          in   1   single clock; all state updates on posedge
//  Reset        in   1   synchronous, active-high reset
//  Req          in   4   per-channel request; Req[i] high = channel i has data on mux input i
//  Beat         in   1   downstream accepted the current mux output this cycle
//  Control      out  2   mux select, registered; 0=A, 1=B, 2=C, 3=D
//  Grant        out  4   one-hot owner, registered; 0 when idle
//  Grant_Valid  out  1   high while a channel owns the mux
// BEHAVIOUR
//  Reset values (sampled at Clk while Reset=1):
//   - Control=2'b00, Grant=4'b0000, Grant_Valid=0.
//   - Beat counter=0, state=IDLE.
//   - Last-owner pointer=3, so channel 0 has first priority.
//  Reset dominates all other inputs, including mid-burst; the in-flight grant is dropped with no completion.
//  States: IDLE, OWN.
//  IDLE:
//   - Req==0: stay in IDLE. Control keeps the last owner's value so the mux output stays stable.
//   - Req!=0: winner = first set Req bit scanning Last+1, Last+2, ... modulo 4 (wraps 3->0).
//   - Next edge after a winner is found: Control=winner, Grant=1<<winner, Grant_Valid=1, Last=winner, counter=0, go to OWN.
//   - Latency Req -> Grant_Valid is exactly 1 cycle.
//  OWN:
//   - Beat=1: counter increments.
//   - Release when, at the edge, either:
//     (a) Req[owner]==0, or
//     (b) Beat==1 and counter==Max_Burst-1.
//   - On release, next edge: Grant=0, Grant_Valid=0, go to IDLE. Control keeps its value.
//   - Every release therefore forces one idle cycle before the next grant.
//   - Beat and Req[owner] falling in the same cycle: the beat is counted and the channel releases.
//   - Req bits of non-owners are ignored in OWN.
//   - Changing Req bits never alters Control or Grant mid-grant.
//  Beat while Grant_Valid=0: ignored, no counter change.
//  Max_Burst=1: the first accepted beat releases the grant.
//  Invariants:
//   - Grant is always zero or one-hot.
//   - When Grant_Valid=1, Grant == 1<<Control.
//   - Counter never exceeds Max_Burst-1.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  T1 reset: Reset=1 for 2 cycles, Req=4'b1111 -> Control=0, Grant=0, Grant_Valid=0 throughout; first grant goes to ch0.
//  T2 single req: after reset, Req=4'b0100 at cycle n -> at n+1 Grant=4'b0100, Control=2, Grant_Valid=1.
//  T3 fairness: Req=4'b1111 held, Beat=1 held, Max_Burst=4 -> grants 0,1,2,3,0, each 4 cycles with Grant_Valid=1, separated by 1 idle cycle.
//  T4 early drop: ch1 owns, 2 beats accepted, then Req[1]=0 -> Grant_Valid=0 next cycle; with Req=4'b1001, the next grant goes to ch3, not ch0.
//  T5 reset mid-burst: ch2 owns, counter=2, Reset=1 for 1 cycle -> all outputs return to reset values; with Req=4'b0100, ch2 is re-granted 1 cycle after Reset falls, counter=0.
//  T6 idle Beat / simultaneous events: Beat=1 with Req=0 -> no state change; Beat=1 with the owner's Req falling in the same cycle -> beat counted, released next edge.

Source files
------------

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 datapath mux.
// Each grant lasts until the owner drops its request or Max_Burst beats are accepted.
module rr_select_arbiter #(
    parameter int Max_Burst = 4,
    parameter int Cnt_Width = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Req,
    input  logic       Beat,
    output logic [1:0] Control,
    output logic [3:0] Grant,
    output logic       Grant_Valid
);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    localparam logic [Cnt_Width-1:0] CNT_LAST = Cnt_Width'(Max_Burst - 1);

    state_t               state_q, state_d;
    logic [1:0]           last_q, last_d;
    logic [1:0]           control_q, control_d;
    logic [3:0]           grant_q, grant_d;
    logic                 gvalid_q, gvalid_d;
    logic [Cnt_Width-1:0] cnt_q, cnt_d;

    logic                 win_found;
    logic [1:0]           win_idx;
    logic [1:0]           scan_idx;
    logic                 burst_done;
    logic                 release_own;

    // Scan starts just past the last owner so every channel gets its turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        scan_idx  = last_q;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = last_q + 2'(k);
            if (!win_found && Req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign burst_done  = Beat && (cnt_q == CNT_LAST);
    assign release_own = !Req[control_q] || burst_done;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        control_d = control_q;
        grant_d   = grant_q;
        gvalid_d  = gvalid_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    control_d = win_idx;
                    grant_d   = 4'b0001 << win_idx;
                    gvalid_d  = 1'b1;
                    last_d    = win_idx;
                    cnt_d     = '0;
                    state_d   = OWN;
                end
            end
            OWN: begin
                if (release_own) begin
                    grant_d  = 4'b0000;
                    gvalid_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else if (Beat) begin
                    cnt_d = cnt_q + Cnt_Width'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            last_q    <= 2'd3;
            control_q <= 2'd0;
            grant_q   <= 4'b0000;
            gvalid_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            control_q <= control_d;
            grant_q   <= grant_d;
            gvalid_q  <= gvalid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign Control     = control_q;
    assign Grant       = grant_q;
    assign Grant_Valid = gvalid_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed bench for rr_select_arbiter with hand-computed expectations.
module tb_rr_select_arbiter;

    logic       Clk;
    logic       Reset;
    logic [3:0] Req;
    logic       Beat;
    logic [1:0] Control;
    logic [3:0] Grant;
    logic       Grant_Valid;

    int checks;
    int errors;

    rr_select_arbiter #(.Max_Burst(4), .Cnt_Width(8)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Req         (Req),
        .Beat        (Beat),
        .Control     (Control),
        .Grant       (Grant),
        .Grant_Valid (Grant_Valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Req   = 4'b0000;
        Beat  = 1'b0;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Req   = 4'b1111;
        Beat  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (Control !== 2'd0 || Grant !== 4'b0000 || Grant_Valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got C=%0d G=%b V=%b want C=0 G=0000 V=0",
                         i, Control, Grant, Grant_Valid);
            end
        end
        Reset = 1'b0;
        step();
        checks++;
        if (Control !== 2'd0 || Grant !== 4'b0001 || Grant_Valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: got C=%0d G=%b V=%b want C=0 G=0001 V=1",
                     Control, Grant, Grant_Valid);
        end
    endtask

    task automatic test_single_req();
        do_reset();
        Req = 4'b0100;
        step();
        checks++;
        if (Control !== 2'd2 || Grant !== 4'b0100 || Grant_Valid !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got C=%0d G=%b V=%b want C=2 G=0100 V=1",
                     Control, Grant, Grant_Valid);
        end
        Req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (Control !== 2'd2 || Grant !== 4'b0000 || Grant_Valid !== 1'b0) begin
                errors++;
                $display("FAIL single_release cyc%0d: got C=%0d G=%b V=%b want C=2 G=0000 V=0",
                         i, Control, Grant, Grant_Valid);
            end
        end
    endtask

    task automatic test_fairness();
        logic [1:0] order [5];
        logic [3:0] exp_g;
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        do_reset();
        Req  = 4'b1111;
        Beat = 1'b1;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << order[g];
            for (int i = 0; i < 4; i++) begin
                step();
                checks++;
                if (Control !== order[g] || Grant !== exp_g || Grant_Valid !== 1'b1) begin
                    errors++;
                    $display("FAIL fair_own g%0d beat%0d: got C=%0d G=%b V=%b want C=%0d G=%b V=1",
                             g, i, Control, Grant, Grant_Valid, order[g], exp_g);
                end
            end
            step();
            checks++;
            if (Grant !== 4'b0000 || Grant_Valid !== 1'b0 || Control !== order[g]) begin
                errors++;
                $display("FAIL fair_idle g%0d: got C=%0d G=%b V=%b want C=%0d G=0000 V=0",
                         g, Control, Grant, Grant_Valid, order[g]);
            end
        end
        Beat = 1'b0;
        Req  = 4'b0000;
    endtask

    task automatic test_early_drop();
        do_reset();
        Req = 4'b0010;
        step();
        checks++;
        if (Grant !== 4'b0010 || Control !== 2'd1) begin
            errors++;
            $display("FAIL drop_grant1: got C=%0d G=%b want C=1 G=0010", Control, Grant);
        end
        Beat = 1'b1;
        step();
        step();
        checks++;
        if (Grant !== 4'b0010 || Grant_Valid !== 1'b1) begin
            errors++;
            $display("FAIL drop_hold: got G=%b V=%b want G=0010 V=1", Grant, Grant_Valid);
        end
        Beat = 1'b0;
        Req  = 4'b1001;
        step();
        checks++;
        if (Grant !== 4'b0000 || Grant_Valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_release: got G=%b V=%b want G=0000 V=0", Grant, Grant_Valid);
        end
        step();
        checks++;
        if (Grant !== 4'b1000 || Control !== 2'd3 || Grant_Valid !== 1'b1) begin
            errors++;
            $display("FAIL drop_next_rr: got C=%0d G=%b V=%b want C=3 G=1000 V=1",
                     Control, Grant, Grant_Valid);
        end
        Req = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        Req = 4'b0100;
        step();
        Beat = 1'b1;
        step();
        step();
        Beat  = 1'b0;
        Reset = 1'b1;
        step();
        checks++;
        if (Control !== 2'd0 || Grant !== 4'b0000 || Grant_Valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_values: got C=%0d G=%b V=%b want C=0 G=0000 V=0",
                     Control, Grant, Grant_Valid);
        end
        Reset = 1'b0;
        step();
        checks++;
        if (Control !== 2'd2 || Grant !== 4'b0100 || Grant_Valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_regrant: got C=%0d G=%b V=%b want C=2 G=0100 V=1",
                     Control, Grant, Grant_Valid);
        end
        Beat = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (Grant_Valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_cnt_cleared: got V=%b after 3 beats want V=1", Grant_Valid);
        end
        step();
        checks++;
        if (Grant_Valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_burst_end: got V=%b after 4 beats want V=0", Grant_Valid);
        end
        Beat = 1'b0;
        Req  = 4'b0000;
        step();
    endtask

    task automatic test_idle_beat_and_simul();
        do_reset();
        Beat = 1'b1;
        step();
        step();
        checks++;
        if (Control !== 2'd0 || Grant !== 4'b0000 || Grant_Valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_beat: got C=%0d G=%b V=%b want C=0 G=0000 V=0",
                     Control, Grant, Grant_Valid);
        end
        Beat = 1'b0;
        Req  = 4'b0001;
        step();
        Beat = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (Grant !== 4'b0001 || Grant_Valid !== 1'b1) begin
            errors++;
            $display("FAIL idle_beat_nocount: got G=%b V=%b after 3 beats want G=0001 V=1",
                     Grant, Grant_Valid);
        end
        step();
        checks++;
        if (Grant_Valid !== 1'b0) begin
            errors++;
            $display("FAIL burst4_release: got V=%b want V=0", Grant_Valid);
        end
        Beat = 1'b0;
        Req  = 4'b0010;
        step();
        checks++;
        if (Grant !== 4'b0010 || Control !== 2'd1) begin
            errors++;
            $display("FAIL simul_grant: got C=%0d G=%b want C=1 G=0010", Control, Grant);
        end
        Beat = 1'b1;
        Req  = 4'b0000;
        step();
        checks++;
        if (Grant !== 4'b0000 || Grant_Valid !== 1'b0 || Control !== 2'd1) begin
            errors++;
            $display("FAIL simul_release: got C=%0d G=%b V=%b want C=1 G=0000 V=0",
                     Control, Grant, Grant_Valid);
        end
        Beat = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        Req    = 4'b0000;
        Beat   = 1'b0;
        test_reset();
        test_single_req();
        test_fairness();
        test_early_drop();
        test_reset_mid_burst();
        test_idle_beat_and_simul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
